divide_unit: RTL and testbench

- Multi-cycle unsigned integer divider using the restoring shift/subtract method, one quotient bit per clock.
- Computes Q = A / B and R = A % B on a start request and reports completion on ok, or divide-by-zero on err.
- A standalone arithmetic block with a level start / done-hold handshake, for datapaths that can tolerate WIDTH-cycle latency.

---
 rtl/divide_unit.sv | 151 +++++++++++++++
 tb/tb_divide_unit.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/divide_unit.sv
// divide_unit: multi-cycle unsigned restoring divider, one quotient bit per clock.
//
// Ports:
//   clk    - system clock, all state changes on the rising edge
//   reset  - synchronous, active-high reset (highest priority)
//   start  - level request; sampled only in IDLE
//   A, B   - unsigned dividend / divisor
//   Q, R   - registered quotient / remainder; hold their last result
//   ok     - result valid, high only in DONE after a successful division
//   err    - divide-by-zero, high only in DONE after a B==0 request
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; Q/R show the previous result
// BUSY  | one shift/subtract iteration per edge, MSB first
// DONE  | result (ok) or divide-by-zero (err) held until start drops

module divide_unit #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             ok,
    output logic             err
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_n;

    logic [WIDTH-1:0] dvd;      // dividend, shifted left as bits are consumed
    logic [WIDTH-1:0] dvs;      // latched divisor
    logic [WIDTH-1:0] quo;      // quotient bits collected so far
    logic [WIDTH:0]   part;     // partial remainder, one spare bit for the compare
    logic [CW-1:0]    cnt;      // iterations remaining

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   part_n;
    logic [WIDTH-1:0] quo_n;
    logic             fits;
    logic             last;

    // One restoring iteration: bring in the next dividend bit, then subtract
    // only if the divisor fits.
    always_comb begin
        shifted = (part << 1) | {{WIDTH{1'b0}}, dvd[WIDTH-1]};
        diff    = shifted - {1'b0, dvs};
        fits    = (shifted >= {1'b0, dvs});
        part_n  = fits ? diff : shifted;
        quo_n   = (quo << 1) | {{(WIDTH-1){1'b0}}, fits};
        last    = (cnt == CW'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = (B == '0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dvd  <= '0;
            dvs  <= '0;
            quo  <= '0;
            part <= '0;
            cnt  <= '0;
            Q    <= '0;
            R    <= '0;
            ok   <= 1'b0;
            err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ok  <= 1'b0;
                    err <= 1'b0;
                    if (start) begin
                        if (B == '0) begin
                            Q   <= '1;
                            R   <= A;
                            err <= 1'b1;
                        end else begin
                            dvd  <= A;
                            dvs  <= B;
                            quo  <= '0;
                            part <= '0;
                            cnt  <= CW'(WIDTH);
                        end
                    end
                end
                BUSY: begin
                    dvd  <= dvd << 1;
                    part <= part_n;
                    quo  <= quo_n;
                    cnt  <= cnt - CW'(1);
                    if (last) begin
                        Q  <= quo_n;
                        R  <= part_n[WIDTH-1:0];
                        ok <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        ok  <= 1'b0;
                        err <= 1'b0;
                    end
                end
                default: begin
                    ok  <= 1'b0;
                    err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divide_unit.sv
// tb_divide_unit: directed vectors for divide_unit. The stimulus pushes each
// expected result into a queue; a monitor pops and compares whenever ok or
// err rises. Latency, hold behaviour and reset are checked inline.

module tb_divide_unit;

    localparam int W = 5;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         ok;
    logic         err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         ok;
        logic         err;
    } exp_t;

    exp_t sb[$];

    logic [W-1:0] hold_q = '0;
    logic [W-1:0] hold_r = '0;
    logic         prev_flag = 1'b0;

    always #5 clk = ~clk;

    divide_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .A     (a),
        .B     (b),
        .Q     (q),
        .R     (r),
        .ok    (ok),
        .err   (err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every rising ok/err is one completed request.
    always @(negedge clk) begin
        exp_t e;
        if ((ok | err) && !prev_flag) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got q=%0d r=%0d ok=%0b err=%0b want none", q, r, ok, err);
            end else begin
                e = sb.pop_front();
                check("sb_q",   q,   e.q);
                check("sb_r",   r,   e.r);
                check("sb_ok",  ok,  e.ok);
                check("sb_err", err, e.err);
            end
        end
        prev_flag = ok | err;
    end

    task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                           input logic [W-1:0] eq, input logic [W-1:0] er,
                           input int hold, input bit scramble);
        exp_t e;
        int   n;
        bit   done;
        logic eok;
        eok   = (bv != '0);
        e.q   = eq;
        e.r   = er;
        e.ok  = eok;
        e.err = !eok;
        sb.push_back(e);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        n    = 0;
        done = ok | err;
        while (!done && n < 20) begin
            check("busy_q_hold", q, hold_q);
            check("busy_r_hold", r, hold_r);
            if (scramble && n == 1) begin
                a = 5'd3;
                b = 5'd1;
            end
            tick();
            n++;
            done = ok | err;
        end
        check("latency", n, eok ? W : 0);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_ok",  ok,  eok);
            check("hold_err", err, !eok);
            check("hold_q",   q,   eq);
            check("hold_r",   r,   er);
        end
        start = 1'b0;
        tick();
        check("drop_ok",  ok,  1'b0);
        check("drop_err", err, 1'b0);
        check("drop_q",   q,   eq);
        check("drop_r",   r,   er);
        hold_q = eq;
        hold_r = er;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        a     = 5'd22;
        b     = 5'd10;
        repeat (10) tick();
        check("rst_q",   q,   0);
        check("rst_r",   r,   0);
        check("rst_ok",  ok,  0);
        check("rst_err", err, 0);
        reset = 1'b0;

        run_div(5'd22, 5'd10, 5'd2,  5'd2, 9, 1'b0);
        run_div(5'd31, 5'd1,  5'd31, 5'd0, 0, 1'b0);
        run_div(5'd5,  5'd7,  5'd0,  5'd5, 0, 1'b0);
        run_div(5'd31, 5'd31, 5'd1,  5'd0, 0, 1'b0);
        run_div(5'd0,  5'd3,  5'd0,  5'd0, 0, 1'b0);
        run_div(5'd9,  5'd0,  5'd31, 5'd9, 1, 1'b0);
        run_div(5'd22, 5'd10, 5'd2,  5'd2, 0, 1'b1);

        // Abort in the third BUSY cycle.
        a     = 5'd22;
        b     = 5'd10;
        start = 1'b1;
        tick();
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("abort_q",   q,   0);
        check("abort_r",   r,   0);
        check("abort_ok",  ok,  0);
        check("abort_err", err, 0);
        reset = 1'b0;
        start = 1'b0;
        tick();
        hold_q = '0;
        hold_r = '0;

        run_div(5'd17, 5'd4,  5'd4, 5'd1, 0, 1'b0);
        run_div(5'd22, 5'd10, 5'd2, 5'd2, 0, 1'b0);
        run_div(5'd30, 5'd7,  5'd4, 5'd2, 0, 1'b0);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
